// File: rtl/ethernet_cfg_master.sv
// Avalon-MM master that soft-resets the Ethernet MAC, programs its station
// address and frame length, enables TX/RX, and reports done or error.
module ethernet_cfg_master #(
  parameter int unsigned FRM_LENGTH  = 1518,
  parameter int unsigned MAX_POLLS   = 16,
  parameter int unsigned RDV_TIMEOUT = 255
) (
  input  logic        clk_clk,
  input  logic        reset_reset_n,
  input  logic        start,
  input  logic [47:0] mac_addr,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [10:0] avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic [31:0] avm_writedata,
  output logic [3:0]  avm_byteenable,
  output logic [4:0]  avm_burstcount,
  input  logic [31:0] avm_readdata,
  input  logic        avm_readdatavalid,
  input  logic        avm_waitrequest
);

  localparam int unsigned RW  = (RDV_TIMEOUT < 1) ? 1 : $clog2(RDV_TIMEOUT + 1);
  localparam int unsigned PW0 = $clog2(MAX_POLLS + 1);
  localparam int unsigned PW  = (PW0 < 5) ? 5 : PW0;
  localparam logic [RW-1:0] RDV_LIMIT  = RW'(RDV_TIMEOUT);
  localparam logic [PW-1:0] POLL_LIMIT = PW'(MAX_POLLS);

  typedef enum logic [2:0] {
    IDLE, WR, RD, WAIT_RDV, CHECK, DONE, ERR
  } state_e;

  state_e        state_q, state_d;
  logic [2:0]    step_q, step_d;
  logic [47:0]   mac_q, mac_d;
  logic [RW-1:0] rdv_cnt_q, rdv_cnt_d;
  logic [PW-1:0] poll_cnt_q, poll_cnt_d;
  logic [2:0]    rbits_q, rbits_d;   // {SW_RESET, RX_ENA, TX_ENA} from last read
  logic [10:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          rd_q, rd_d;
  logic          wr_q, wr_d;

  logic          launch;
  logic [2:0]    launch_step;
  logic [PW-1:0] poll_next;
  logic          unused_rdata;

  assign unused_rdata = ^{avm_readdata[31:14], avm_readdata[12:2]};

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      state_q    <= IDLE;
      step_q     <= '0;
      mac_q      <= '0;
      rdv_cnt_q  <= '0;
      poll_cnt_q <= '0;
      rbits_q    <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= 1'b0;
      wr_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      step_q     <= step_d;
      mac_q      <= mac_d;
      rdv_cnt_q  <= rdv_cnt_d;
      poll_cnt_q <= poll_cnt_d;
      rbits_q    <= rbits_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rd_q       <= rd_d;
      wr_q       <= wr_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    step_d      = step_q;
    mac_d       = mac_q;
    rdv_cnt_d   = rdv_cnt_q;
    poll_cnt_d  = poll_cnt_q;
    rbits_d     = rbits_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    launch      = 1'b0;
    launch_step = step_q;
    poll_next   = (poll_cnt_q == '1) ? poll_cnt_q : poll_cnt_q + PW'(1);

    case (state_q)
      IDLE, DONE, ERR: begin
        if (start) begin
          mac_d       = mac_addr;
          poll_cnt_d  = '0;
          launch      = 1'b1;
          launch_step = 3'd0;
        end
      end
      // WR has two phases: command high until accepted, then one idle
      // cycle with the command dropped before the next step is launched.
      WR: begin
        if (wr_q) begin
          if (!avm_waitrequest) begin
            wr_d   = 1'b0;
            step_d = step_q + 3'd1;
            if (step_q == 3'd0) poll_cnt_d = '0;
          end
        end else begin
          launch      = 1'b1;
          launch_step = step_q;
        end
      end
      RD: begin
        if (!avm_waitrequest) begin
          rd_d      = 1'b0;
          rdv_cnt_d = '0;
          state_d   = WAIT_RDV;
        end
      end
      WAIT_RDV: begin
        if (avm_readdatavalid) begin
          rbits_d = {avm_readdata[13], avm_readdata[1:0]};
          state_d = CHECK;
        end else if (rdv_cnt_q == RDV_LIMIT) begin
          state_d = ERR;
        end else begin
          rdv_cnt_d = rdv_cnt_q + RW'(1);
        end
      end
      CHECK: begin
        if (step_q == 3'd1) begin
          poll_cnt_d = poll_next;
          if (!rbits_q[2]) begin
            launch      = 1'b1;
            launch_step = 3'd2;
          end else if (poll_next >= POLL_LIMIT) begin
            state_d = ERR;
          end else begin
            launch      = 1'b1;
            launch_step = 3'd1;
          end
        end else if (step_q == 3'd6) begin
          state_d = (rbits_q[1:0] == 2'b11) ? DONE : ERR;
        end else begin
          state_d = ERR;
        end
      end
      default: state_d = IDLE;
    endcase

    if (launch) begin
      step_d = launch_step;
      rd_d   = 1'b0;
      wr_d   = 1'b0;
      case (launch_step)
        3'd0: begin wr_d = 1'b1; addr_d = 11'h002; wdata_d = 32'h0000_2000; state_d = WR; end
        3'd1: begin rd_d = 1'b1; addr_d = 11'h002; state_d = RD; end
        3'd2: begin wr_d = 1'b1; addr_d = 11'h003; wdata_d = mac_d[31:0]; state_d = WR; end
        3'd3: begin wr_d = 1'b1; addr_d = 11'h004; wdata_d = {16'h0, mac_d[47:32]}; state_d = WR; end
        3'd4: begin wr_d = 1'b1; addr_d = 11'h005; wdata_d = 32'(FRM_LENGTH); state_d = WR; end
        3'd5: begin wr_d = 1'b1; addr_d = 11'h002; wdata_d = 32'h0000_0003; state_d = WR; end
        3'd6: begin rd_d = 1'b1; addr_d = 11'h002; state_d = RD; end
        default: state_d = ERR;
      endcase
    end
  end

  assign busy           = (state_q == WR) || (state_q == RD) ||
                          (state_q == WAIT_RDV) || (state_q == CHECK);
  assign done           = (state_q == DONE);
  assign error          = (state_q == ERR);
  assign avm_address    = addr_q;
  assign avm_writedata  = wdata_q;
  assign avm_read       = rd_q;
  assign avm_write      = wr_q;
  assign avm_byteenable = 4'hF;
  assign avm_burstcount = 5'd1;

endmodule

// File: tb/tb_ethernet_cfg_master.sv
// Bench for ethernet_cfg_master: acts as the CSR slave and compares the
// accepted transaction list and final status against a sequence-level model.
module tb_ethernet_cfg_master;

  localparam int unsigned FRM_LENGTH  = 1518;
  localparam int unsigned MAX_POLLS   = 16;
  localparam int unsigned RDV_TIMEOUT = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [47:0] mac_addr;
  logic        busy, done, error;
  logic [10:0] avm_address;
  logic        avm_read, avm_write;
  logic [31:0] avm_writedata;
  logic [3:0]  avm_byteenable;
  logic [4:0]  avm_burstcount;
  logic [31:0] avm_readdata;
  logic        avm_readdatavalid;
  logic        avm_waitrequest;

  always #5 clk = ~clk;

  ethernet_cfg_master #(
    .FRM_LENGTH (FRM_LENGTH),
    .MAX_POLLS  (MAX_POLLS),
    .RDV_TIMEOUT(RDV_TIMEOUT)
  ) dut (
    .clk_clk          (clk),
    .reset_reset_n    (rst_n),
    .start            (start),
    .mac_addr         (mac_addr),
    .busy             (busy),
    .done             (done),
    .error            (error),
    .avm_address      (avm_address),
    .avm_read         (avm_read),
    .avm_write        (avm_write),
    .avm_writedata    (avm_writedata),
    .avm_byteenable   (avm_byteenable),
    .avm_burstcount   (avm_burstcount),
    .avm_readdata     (avm_readdata),
    .avm_readdatavalid(avm_readdatavalid),
    .avm_waitrequest  (avm_waitrequest)
  );

  typedef struct {
    logic [31:0] data;
    int unsigned delay;
  } resp_t;

  int n_cmp  = 0;
  int n_fail = 0;

  // transaction = {is_read, address, writedata (0 for reads)}
  logic [43:0] got_q[$];
  logic [43:0] exp_q[$];
  resp_t       stim_q[$];
  resp_t       resp_q[$];
  bit          exp_done, exp_err;

  int unsigned stall_cfg, cur_wait, rdv_wait;
  bit          in_cmd, rdv_pending, spur_en;
  logic [44:0] snap;
  logic [31:0] rdv_data;
  int          stab_err, both_err;

  task automatic build_model(input logic [47:0] mac);
    resp_t       r;
    int unsigned idx, polls;
    bit          cleared;
    exp_q.delete();
    exp_done = 0; exp_err = 0; idx = 0; polls = 0; cleared = 0;
    exp_q.push_back({1'b0, 11'h002, 32'h0000_2000});
    while (!exp_err && !cleared) begin
      r.data = '0; r.delay = 0;
      if (idx < stim_q.size()) r = stim_q[idx];
      idx++;
      exp_q.push_back({1'b1, 11'h002, 32'h0});
      polls++;
      if (r.delay > RDV_TIMEOUT) exp_err = 1;
      else if (r.data[13] == 1'b0) cleared = 1;
      else if (polls >= MAX_POLLS) exp_err = 1;
    end
    if (!exp_err) begin
      exp_q.push_back({1'b0, 11'h003, mac[31:0]});
      exp_q.push_back({1'b0, 11'h004, 16'h0, mac[47:32]});
      exp_q.push_back({1'b0, 11'h005, 32'(FRM_LENGTH)});
      exp_q.push_back({1'b0, 11'h002, 32'h0000_0003});
      exp_q.push_back({1'b1, 11'h002, 32'h0});
      r.data = '0; r.delay = 0;
      if (idx < stim_q.size()) r = stim_q[idx];
      if (r.delay > RDV_TIMEOUT) exp_err = 1;
      else if (r.data[1:0] == 2'b11) exp_done = 1;
      else exp_err = 1;
    end
  endtask

  task automatic slave_reset();
    in_cmd = 0; rdv_pending = 0; cur_wait = 0; rdv_wait = 0;
    stab_err = 0; both_err = 0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
  endtask

  // Called once per negedge: checks protocol, then drives the slave inputs.
  task automatic slave_cycle();
    resp_t r;
    if (avm_read && avm_write) both_err++;
    if (rdv_pending) begin
      if (rdv_wait == 0) begin
        avm_readdatavalid = 1'b1; avm_readdata = rdv_data; rdv_pending = 0;
      end else begin
        avm_readdatavalid = 1'b0; avm_readdata = $urandom; rdv_wait--;
      end
    end else if (spur_en && $urandom_range(0, 3) == 0) begin
      avm_readdatavalid = 1'b1; avm_readdata = $urandom;
    end else begin
      avm_readdatavalid = 1'b0;
    end
    if (avm_read || avm_write) begin
      if (!in_cmd) begin
        in_cmd = 1; cur_wait = stall_cfg;
        snap = {avm_read, avm_write, avm_address, avm_writedata};
      end else if ({avm_read, avm_write, avm_address, avm_writedata} !== snap) begin
        stab_err++;
      end
      if (cur_wait > 0) begin
        avm_waitrequest = 1'b1; cur_wait--;
      end else begin
        avm_waitrequest = 1'b0; in_cmd = 0;
        got_q.push_back({avm_read, avm_address, avm_read ? 32'h0 : avm_writedata});
        if (avm_read) begin
          r.data = '0; r.delay = 0;
          if (resp_q.size() > 0) r = resp_q.pop_front();
          rdv_pending = 1; rdv_wait = r.delay; rdv_data = r.data;
        end
      end
    end else begin
      avm_waitrequest = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic run_and_check(input string name, input logic [47:0] mac,
                               input int unsigned stall, input bit spur,
                               input int busy_start_at);
    bit finished;
    int extra;
    int n;
    got_q.delete();
    resp_q = stim_q;
    build_model(mac);
    slave_reset();
    stall_cfg = stall; spur_en = spur;
    finished = 0; extra = 0;
    @(negedge clk);
    start = 1'b1; mac_addr = mac;
    slave_cycle();
    for (int cyc = 0; cyc < 20000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 0) mac_addr = {$urandom, $urandom};
      slave_cycle();
      if (cyc == busy_start_at && busy) begin
        start = 1'b1; mac_addr = ~mac;
      end
      if (!busy && (done || error)) extra++;
      if (extra >= 8) begin finished = 1; break; end
    end
    start = 1'b0;
    n_cmp++;
    if (finished !== 1'b1) begin
      n_fail++;
      $display("FAIL %s completion: busy=%0b done=%0b error=%0b, required end of sequence within budget", name, busy, done, error);
    end
    n_cmp++;
    if (got_q.size() != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s txn_count: got %0d, expected %0d", name, got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (got_q[i] !== exp_q[i]) begin
        n_fail++;
        $display("FAIL %s txn[%0d]: got rd=%0b addr=%h data=%h, expected rd=%0b addr=%h data=%h",
                 name, i, got_q[i][43], got_q[i][42:32], got_q[i][31:0],
                 exp_q[i][43], exp_q[i][42:32], exp_q[i][31:0]);
      end
    end
    n_cmp++;
    if (done !== exp_done) begin
      n_fail++; $display("FAIL %s done: got %0b, expected %0b", name, done, exp_done);
    end
    n_cmp++;
    if (error !== exp_err) begin
      n_fail++; $display("FAIL %s error: got %0b, expected %0b", name, error, exp_err);
    end
    n_cmp++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL %s busy: got %0b, expected 0", name, busy);
    end
    n_cmp++;
    if (stab_err != 0) begin
      n_fail++; $display("FAIL %s stall_stability: %0d changes while stalled, expected 0", name, stab_err);
    end
    n_cmp++;
    if (both_err != 0) begin
      n_fail++; $display("FAIL %s rd_wr_exclusive: %0d cycles both high, expected 0", name, both_err);
    end
  endtask

  task automatic push_resp(input logic [31:0] d, input int unsigned dly);
    resp_t r;
    r.data = d; r.delay = dly;
    stim_q.push_back(r);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, error, avm_read, avm_write, avm_address, avm_writedata} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: busy=%0b done=%0b err=%0b rd=%0b wr=%0b addr=%h wdata=%h, expected all 0",
               busy, done, error, avm_read, avm_write, avm_address, avm_writedata);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({busy, done, error, avm_read, avm_write} !== '0) begin
      n_fail++;
      $display("FAIL idle_after_reset: busy=%0b done=%0b err=%0b rd=%0b wr=%0b, expected all 0",
               busy, done, error, avm_read, avm_write);
    end
    n_cmp++;
    if ({avm_byteenable, avm_burstcount} !== {4'hF, 5'd1}) begin
      n_fail++;
      $display("FAIL const_outputs: be=%h burst=%0d, expected be=f burst=1", avm_byteenable, avm_burstcount);
    end
  endtask

  task automatic test_basic();
    stim_q.delete();
    push_resp(32'h0000_0000, 0);
    push_resp(32'h0000_0003, 0);
    run_and_check("basic", 48'h0011_2233_4455, 0, 0, -1);
  endtask

  task automatic test_stall();
    stim_q.delete();
    push_resp(32'h0000_2000, 1);
    push_resp(32'h0000_0000, 2);
    push_resp(32'h0000_0003, 0);
    run_and_check("stall5", 48'hA1B2_C3D4_E5F6, 5, 0, -1);
  endtask

  task automatic test_poll_timeout();
    stim_q.delete();
    for (int i = 0; i < 20; i++) push_resp(32'h0000_2000, 0);
    run_and_check("poll_timeout", 48'h0102_0304_0506, 0, 0, -1);
  endtask

  task automatic test_rdv_timeout();
    stim_q.delete();
    push_resp(32'h0000_0000, 256);
    push_resp(32'h0000_0003, 0);
    run_and_check("rdv_none", 48'h1111_2222_3333, 0, 0, -1);
    stim_q.delete();
    push_resp(32'h0000_0000, 255);
    push_resp(32'h0000_0003, 255);
    run_and_check("rdv_at_limit", 48'h4444_5555_6666, 1, 0, -1);
  endtask

  task automatic test_bad_readback();
    stim_q.delete();
    push_resp(32'h0000_0000, 0);
    push_resp(32'h0000_0001, 0);
    run_and_check("bad_readback", 48'h0011_2233_4455, 0, 0, -1);
  endtask

  task automatic test_random();
    int unsigned polls, d;
    logic [31:0] v;
    for (int it = 0; it < 8; it++) begin
      stim_q.delete();
      polls = $urandom_range(0, MAX_POLLS);
      for (int unsigned p = 0; p <= polls; p++) begin
        d = $urandom_range(0, 3);
        if ($urandom_range(0, 15) == 0) d = 255 + $urandom_range(0, 1);
        v = $urandom;
        v[13] = (p < polls);
        push_resp(v, d);
      end
      v = $urandom;
      if ($urandom_range(0, 1) == 1) v[1:0] = 2'b11;
      push_resp(v, $urandom_range(0, 4));
      run_and_check($sformatf("random%0d", it), {$urandom, $urandom},
                    $urandom_range(0, 3), 1, $urandom_range(2, 40));
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    stim_q.delete();
    push_resp(32'h0000_0000, 0);
    push_resp(32'h0000_0003, 0);
    got_q.delete();
    resp_q = stim_q;
    slave_reset();
    stall_cfg = 5; spur_en = 0; found = 0;
    @(negedge clk);
    start = 1'b1; mac_addr = 48'hDEAD_BEEF_CAFE;
    slave_cycle();
    for (int cyc = 0; cyc < 500; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      slave_cycle();
      if (avm_write && avm_address == 11'h004 && avm_waitrequest) begin
        found = 1; break;
      end
    end
    n_cmp++;
    if (found !== 1'b1) begin
      n_fail++; $display("FAIL reset_mid reach_step3: not found, expected step-3 stall");
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, done, error, avm_read, avm_write, avm_address, avm_writedata} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid async_clear: busy=%0b done=%0b err=%0b rd=%0b wr=%0b addr=%h wdata=%h, expected all 0",
               busy, done, error, avm_read, avm_write, avm_address, avm_writedata);
    end
    slave_reset();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    got_q.delete();
    for (int cyc = 0; cyc < 20; cyc++) begin
      @(negedge clk);
      slave_cycle();
    end
    n_cmp++;
    if (got_q.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid quiet_after_release: %0d txns busy=%0b, expected 0 txns busy=0", got_q.size(), busy);
    end
    run_and_check("rerun_after_reset", 48'h0BAD_F00D_1234, 2, 0, -1);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; mac_addr = '0;
    avm_waitrequest = 1'b0; avm_readdatavalid = 1'b0; avm_readdata = '0;
    test_reset();
    test_basic();
    test_stall();
    test_poll_timeout();
    test_rdv_timeout();
    test_bad_readback();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ethernet_cfg_master.md
ETHERNET_CFG_MASTER -- requirements
Module: ethernet_cfg_master

Interface
REQ-001 Parameter FRM_LENGTH, default 1518: maximum frame length written to MAC frm_length register.
REQ-002 Parameter MAX_POLLS, default 16: maximum reads of command_config while waiting for soft reset to clear.
REQ-003 Parameter RDV_TIMEOUT, default 255: maximum clk_clk cycles from read acceptance to avm_readdatavalid.
REQ-004 clk_clk  in  1  single clock for all logic.
REQ-005 reset_reset_n  in  1  asynchronous, active-low reset.
REQ-006 start  in  1  single-cycle pulse; begins the configuration sequence.
REQ-007 mac_addr  in  48  station MAC address; sampled on accepted start.
REQ-008 busy  out  1  high while the sequence runs.
REQ-009 done  out  1  high after successful completion; held until next start.
REQ-010 error  out  1  high after failure; held until next start.
REQ-011 avm_address  out  11  word address into the ethernet subsystem CSR slave.
REQ-012 avm_read / avm_write  out  1 each  Avalon-MM commands.
REQ-013 avm_writedata  out  32  write data.
REQ-014 avm_byteenable  out  4  constant 4'hF.
REQ-015 avm_burstcount  out  5  constant 5'd1.
REQ-016 avm_readdata  in  32  read data.
REQ-017 avm_readdatavalid  in  1  read data valid.
REQ-018 avm_waitrequest  in  1  slave stall.

Function
REQ-019 States: IDLE, WR, RD, WAIT_RDV, CHECK, DONE, ERR.
REQ-020 start in IDLE, DONE or ERR: clear done/error, latch mac_addr, step=0, set busy, enter the step's WR or RD; start ignored while busy.
REQ-021 Step 0: write addr 0x002 data 32'h0000_2000 (command_config SW_RESET).
REQ-022 Step 1: read 0x002; repeat while bit 13 = 1; after MAX_POLLS reads with bit 13 still set -> ERR.
REQ-023 Step 2: write 0x003 data mac_addr[31:0]; step 3: write 0x004 data {16'h0, mac_addr[47:32]}.
REQ-024 Step 4: write 0x005 data FRM_LENGTH zero-extended to 32 bits.
REQ-025 Step 5: write 0x002 data 32'h0000_0003 (TX_ENA, RX_ENA).
REQ-026 Step 6: read 0x002; bits [1:0] = 2'b11 -> DONE, else -> ERR.
REQ-027 WR/RD: command, address and data held stable while avm_waitrequest = 1; command accepted in the first cycle with avm_waitrequest = 0; command deasserted the following cycle.
REQ-028 At most one transaction outstanding; avm_read and avm_write never high together.
REQ-029 WAIT_RDV: counter starts at 0 on read acceptance, increments per cycle; avm_readdatavalid captures avm_readdata and enters CHECK next cycle; counter reaching RDV_TIMEOUT without valid -> ERR.
REQ-030 avm_readdatavalid in the same cycle as the timeout compare: data wins, no error.
REQ-031 avm_readdatavalid outside WAIT_RDV ignored.
REQ-032 Write steps advance to the next step the cycle after acceptance; no write response is awaited.
REQ-033 DONE: busy=0, done=1; ERR: busy=0, error=1; done and error never both high.
REQ-034 Poll counter 5 bits wide minimum, saturates, cleared on entry to step 1.

Reset
REQ-035 reset_reset_n low asynchronously forces IDLE; busy, done, error, avm_read, avm_write = 0; avm_address, avm_writedata = 0; counters = 0.
REQ-036 Reset mid-transaction abandons it; no command asserted until a new start after reset release.

Verification
REQ-037 mac_addr=48'h0011_2233_4455, start, zero wait, readback 0x0000_0000 then 0x0000_0003 -> writes (0x002,0x2000),(0x003,0x2233_4455),(0x004,0x0000_0011),(0x005,0x0000_05EE),(0x002,0x3); done=1.
REQ-038 avm_waitrequest high 5 cycles on each command -> signals stable during stall, each command accepted exactly once.
REQ-039 Step-1 reads return 0x2000 16 times -> error=1, no further writes, busy=0.
REQ-040 No avm_readdatavalid after a read for 255 cycles -> error=1; valid at cycle 255 instead -> sequence continues.
REQ-041 Step-6 readback 0x0000_0001 -> error=1, done=0.
REQ-042 reset_reset_n asserted during step-3 stall -> outputs zero immediately; new start reruns from step 0.
